alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream stage of the 8-bit ALU (add, sub, and, or, xor, not behind a 3-bit select mux).
- Captures each ALU result with its operands and select, and derives status flags Z/N/C/V.
- Buffers results in a 2-entry FIFO with valid/ready handshakes on both sides, so ALU results can be decoupled from a stalling consumer (register write-back / flag register).
- Also keeps a saturating count of accepted operations.

Parameters:
- WIDTH, 8, data width of operands and result; flags are defined on bit WIDTH-1 as the sign bit.
- DEPTH, 2, FIFO entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  stage can accept; equals (count < 2).
- in_sel  in  3  ALU select: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110/111 reserved.
- in_a  in  WIDTH  operand A as fed to the ALU.
- in_b  in  WIDTH  operand B as fed to the ALU.
- in_res  in  WIDTH  ALU mux output.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head entry.
- out_res  out  WIDTH  head result.
- out_sel  out  3  head select.
- out_z  out  1  zero flag.
- out_n  out  1  negative flag.
- out_c  out  1  carry/borrow flag.
- out_v  out  1  signed overflow flag.
- out_err  out  1  head entry had a reserved select.
- op_count  out  8  accepted transactions, saturating.

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, count=0, read/write pointers=0, op_count=0, and storage contents don't-care. All outputs read 0 after reset: out_valid=0, in_ready=1 from the first cycle after reset, and out_res/out_sel/out_* = 0 while empty (outputs gated by out_valid).
- Reset asserted mid-operation discards all buffered entries with no further out_valid.
- Push on the edge where in_valid && in_ready. Pop on the edge where out_valid && out_ready.
- Latency: an entry pushed at edge k shows out_valid=1 after edge k when the FIFO was empty. No combinational path from in_* to out_*.
- Simultaneous push and pop with count=1: count stays 1 and order is preserved (the pushed entry becomes the next head).
- When count=2, in_ready=0 and in_valid is ignored. A pop in that cycle frees a slot; the next push is accepted in the following cycle. There is no same-cycle push-on-full.
- Pointers are 1 bit each and wrap 1 to 0.
- The producer must hold in_* stable while in_valid && !in_ready. The stage must not drop or duplicate entries.
- Flags are computed at push time from in_sel, in_a, in_b, in_res and stored with the entry:
  - Z = (in_res == 0), all selects.
  - N = in_res[WIDTH-1], all selects.
  - add: C = bit WIDTH of the zero-extended in_a+in_b; V = (a[msb]==b[msb]) && (res[msb]!=a[msb]).
  - sub: C = borrow = (in_a < in_b) unsigned; V = (a[msb]!=b[msb]) && (res[msb]!=a[msb]).
  - and/or/xor/not: C=0, V=0.
  - reserved 110/111: C=0, V=0, err=1 (Z/N still from in_res); err=0 otherwise.
- in_res is taken as-is; the stage does not check it against a+b.
- op_count increments by 1 per push, stops at 255, and clears only on reset.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles -> out_valid=0, in_ready=1, op_count=0, all out_* = 0.
- sel=000, a=5, b=3, res=8 -> next cycle out_valid=1, out_res=8, Z=0 N=0 C=0 V=0. Then sel=001, a=5, b=3, res=2 -> out_res=2, flags all 0. Then sel=001, a=3, b=5, res=0xFE -> N=1 C=1 V=0.
- Arithmetic edges:
  - sel=000, a=0x7F, b=0x01, res=0x80 -> N=1 V=1 C=0.
  - sel=000, a=0xFF, b=0x01, res=0x00 -> Z=1 C=1 V=0.
  - sel=101, a=0xFF, res=0x00 -> Z=1 C=0.
  - sel=110, res=0 -> err=1.
- Backpressure: out_ready=0 and push 3 entries back-to-back (res 1,2,3) -> in_ready=0 after the 2nd push; the 3rd is held. Raise out_ready -> outputs 1,2,3 in order, no loss or duplication, op_count=3.
- Streaming: out_ready=1 with in_valid held for 10 cycles -> one result per cycle, count never exceeds 1, op_count=10. Then 300 pushes -> op_count=255.
- Reset mid-stream with 2 entries buffered -> the next cycle has out_valid=0, in_ready=1, op_count=0, and the old entries never appear.

Source files
------------

// File: rtl/alu_result_stage.sv
// Purpose : captures ALU results with operands/select, derives Z/N/C/V/err, buffers them in a 2-entry FIFO.
// Latency : an entry pushed into an empty stage is visible at the outputs right after the push edge (1 cycle).
// Backpr. : in_ready drops when both entries are occupied; a pop frees a slot for the following cycle only.
//
// Ports:
//   clk, rst_n                      clock (rising edge), synchronous active-low reset
//   in_valid/in_ready               producer handshake; in_sel/in_a/in_b/in_res are the ALU-side fields
//   out_valid/out_ready             consumer handshake; out_res/out_sel/out_z/n/c/v/err describe the head entry
//   op_count                        saturating count of accepted pushes
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [2:0]       out_sel,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic             out_err,
  output logic [7:0]       op_count
);

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b100;
  localparam logic [2:0] SEL_NOT = 3'b101;

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [2:0]       sel;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             err;
  } entry_t;

  // Storage is never reset: its contents are only observable through out_valid.
  entry_t     mem_q [DEPTH];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [7:0] op_count_q, op_count_d;

  logic   push;
  logic   pop;
  logic   add_carry;
  logic   sub_borrow;
  entry_t new_entry;
  entry_t head;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Flag derivation at push time
  // ---------------------------------------------------------------------------
  // a + b overflows WIDTH bits exactly when a > (2^WIDTH - 1 - b), i.e. a > ~b.
  assign add_carry  = (in_a > ~in_b);
  assign sub_borrow = (in_a < in_b);

  always_comb begin
    new_entry     = '0;
    new_entry.res = in_res;
    new_entry.sel = in_sel;
    new_entry.z   = (in_res == '0);
    new_entry.n   = in_res[MSB];
    unique case (in_sel)
      SEL_ADD: begin
        new_entry.c = add_carry;
        new_entry.v = (in_a[MSB] == in_b[MSB]) && (in_res[MSB] != in_a[MSB]);
      end
      SEL_SUB: begin
        new_entry.c = sub_borrow;
        new_entry.v = (in_a[MSB] != in_b[MSB]) && (in_res[MSB] != in_a[MSB]);
      end
      SEL_AND, SEL_OR, SEL_XOR, SEL_NOT: begin
        new_entry.c = 1'b0;
        new_entry.v = 1'b0;
      end
      default: begin
        // Reserved selects: result is passed through but tagged as an error.
        new_entry.err = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    op_count_d = op_count_q;

    if (push) begin
      wr_ptr_d = ~wr_ptr_q;  // 1-bit pointer wraps 1 -> 0 naturally
      if (op_count_q != 8'hFF) begin
        op_count_d = op_count_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Push and pop together leave the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head fields forced to zero while empty so stale storage never leaks.
  // ---------------------------------------------------------------------------
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_res  = head.res;
  assign out_sel  = head.sel;
  assign out_z    = head.z;
  assign out_n    = head.n;
  assign out_c    = head.c;
  assign out_v    = head.v;
  assign out_err  = head.err;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] in_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [2:0] out_sel;
  logic       out_z;
  logic       out_n;
  logic       out_c;
  logic       out_v;
  logic       out_err;
  logic [7:0] op_count;

  int checks   = 0;
  int failures = 0;

  alu_result_stage #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_res    (in_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sel   (out_sel),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_err   (out_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {out_z, out_n, out_c, out_v, out_err};
  endfunction

  // Push one vector into an empty stage, check the head, then pop it.
  // exp_flags is {Z,N,C,V,err}.
  task automatic send_check(input string tag, input logic [2:0] sel, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] res, input logic [4:0] exp_flags);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = sel;
    in_a      = a;
    in_b      = b;
    in_res    = res;
    step();
    in_valid  = 1'b0;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_res"},   out_res,   res);
    chk({tag, "_sel"},   out_sel,   sel);
    chk({tag, "_flags"}, flags(),   exp_flags);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_empty"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'b000;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_res    = 8'h00;
    out_ready = 1'b0;

    // ---- Reset then idle ----
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_op_count",  op_count,  8'd0);
    chk("rst_out_res",   out_res,   8'd0);
    chk("rst_out_sel",   out_sel,   3'd0);
    chk("rst_flags",     flags(),   5'b00000);
    step();
    chk("idle_out_valid", out_valid, 1'b0);

    // ---- Basic ops and arithmetic edges; flags = {Z,N,C,V,err} ----
    send_check("add_5_3",      3'b000, 8'h05, 8'h03, 8'h08, 5'b00000);
    send_check("sub_5_3",      3'b001, 8'h05, 8'h03, 8'h02, 5'b00000);
    send_check("sub_3_5",      3'b001, 8'h03, 8'h05, 8'hFE, 5'b01100);
    send_check("add_7f_01",    3'b000, 8'h7F, 8'h01, 8'h80, 5'b01010);
    send_check("add_ff_01",    3'b000, 8'hFF, 8'h01, 8'h00, 5'b10100);
    send_check("not_ff",       3'b101, 8'hFF, 8'h00, 8'h00, 5'b10000);
    send_check("rsv_110",      3'b110, 8'h00, 8'h00, 8'h00, 5'b10001);
    send_check("rsv_111",      3'b111, 8'h12, 8'h34, 8'h81, 5'b01001);
    send_check("sub_80_01",    3'b001, 8'h80, 8'h01, 8'h7F, 5'b00010);
    send_check("and_f0_3c",    3'b010, 8'hF0, 8'h3C, 8'h30, 5'b00000);
    chk("op_count_after_10", op_count, 8'd10);

    // ---- Backpressure: 3 back-to-back pushes with consumer stalled ----
    out_ready = 1'b0;
    in_sel    = 3'b011;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_valid  = 1'b1;
    in_res    = 8'd1;
    step();                                   // push 1
    chk("bp_ready_after_1", in_ready, 1'b1);
    in_res = 8'd2;
    step();                                   // push 2 -> full
    chk("bp_ready_after_2", in_ready, 1'b0);
    chk("bp_head_1a",       out_res,  8'd1);
    in_res = 8'd3;                            // held while not ready
    step();
    chk("bp_ready_held",    in_ready, 1'b0);
    chk("bp_head_1b",       out_res,  8'd1);
    chk("bp_op_held",       op_count, 8'd12);
    out_ready = 1'b1;
    step();                                   // pop 1, no push (was full)
    chk("bp_head_2",        out_res,  8'd2);
    chk("bp_ready_freed",   in_ready, 1'b1);
    chk("bp_op_no_push",    op_count, 8'd12);
    step();                                   // push 3 and pop 2
    in_valid = 1'b0;
    chk("bp_head_3",        out_res,  8'd3);
    chk("bp_valid_3",       out_valid, 1'b1);
    chk("bp_op_after_3",    op_count, 8'd13);
    step();                                   // pop 3
    chk("bp_drained",       out_valid, 1'b0);

    // ---- Streaming: one result per cycle, occupancy stays at 1 ----
    out_ready = 1'b1;
    in_sel    = 3'b100;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_res = 8'(8'h40 + i);
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_res",   out_res,   8'(8'h40 + i));
      chk("stream_ready", in_ready,  1'b1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", out_valid, 1'b0);
    chk("stream_op",      op_count,  8'd23);

    // ---- Saturation ----
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_res = 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_op_count", op_count, 8'd255);
    chk("sat_drained",  out_valid, 1'b0);

    // ---- Reset mid-stream with 2 entries buffered ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 3'b000;
    in_res    = 8'hAA;
    step();
    in_res = 8'hBB;
    step();
    in_valid = 1'b0;
    chk("mid_full_valid", out_valid, 1'b1);
    chk("mid_full_ready", in_ready,  1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid",  out_valid, 1'b0);
    chk("mid_rst_ready",  in_ready,  1'b1);
    chk("mid_rst_op",     op_count,  8'd0);
    chk("mid_rst_res",    out_res,   8'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_ghost", out_valid, 1'b0);
    end

    // ---- Stage works normally after reset ----
    send_check("post_rst_xor", 3'b100, 8'hAA, 8'h55, 8'hFF, 5'b01000);
    chk("post_rst_op", op_count, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
